// File: rtl/select_de_param.sv
// Clocked die selector: synchronised stepping of die type/count, registered roll bounds, sequential BCD of d_max.
// Optional input lock via `define SELECTD_LOCK_EN (adds port verrou).
module select_de_param #(
    parameter int unsigned NB_TYPES   = 8,
    parameter int unsigned NB_DES_MAX = 4,
    parameter int unsigned W          = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          suivant,
    input  logic          precedent,
    input  logic          mode,
`ifdef SELECTD_LOCK_EN
    input  logic          verrou,
`endif
    output logic [2:0]    id_type,
    output logic [3:0]    nb_des,
    output logic          sel_count,
    output logic [W-1:0]  d_min,
    output logic [W-1:0]  d_max,
    output logic [11:0]   bcd_max,
    output logic          bcd_valid
);

    localparam int unsigned BCD_W = 12;
    localparam int unsigned DD_W  = BCD_W + W;
    localparam int unsigned CNT_W = $clog2(W + 1);

    localparam logic [0:0] ST_TYPE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    localparam logic [2:0] ID_LAST = 3'(NB_TYPES - 1);
    localparam logic [3:0] NB_LAST = 4'(NB_DES_MAX);

    logic [2:0] btn_s1, btn_s2, btn_q, btn_ev;
    logic       lock;

    // Two-flop synchronisers and edge registers for {mode, precedent, suivant}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 3'b000;
            btn_s2 <= 3'b000;
            btn_q  <= 3'b000;
        end else begin
            btn_s1 <= {mode, precedent, suivant};
            btn_s2 <= btn_s1;
            btn_q  <= btn_s2;
        end
    end

`ifdef SELECTD_LOCK_EN
    logic lock_s1, lock_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            lock_s1 <= verrou;
            lock_s2 <= lock_s1;
        end
    end

    assign lock = lock_s2;
`else
    assign lock = 1'b0;
`endif

    // Edges seen while locked are consumed by the edge register, so nothing is queued
    assign btn_ev = btn_s2 & ~btn_q & {3{~lock}};

    logic [0:0] state, state_d;
    logic [2:0] id_type_d;
    logic [3:0] nb_des_d;
    logic       step_up, step_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_TYPE;
            id_type <= 3'd0;
            nb_des  <= 4'd1;
        end else begin
            state   <= state_d;
            id_type <= id_type_d;
            nb_des  <= nb_des_d;
        end
    end

    // Mode wins over steps; opposing steps in one cycle cancel
    always_comb begin
        state_d   = state;
        id_type_d = id_type;
        nb_des_d  = nb_des;
        step_up   = btn_ev[0] && !btn_ev[1];
        step_dn   = btn_ev[1] && !btn_ev[0];
        if (btn_ev[2]) begin
            state_d = (state == ST_TYPE) ? ST_COUNT : ST_TYPE;
        end else if (state == ST_TYPE) begin
            if (step_up)
                id_type_d = (id_type == ID_LAST) ? 3'd0 : id_type + 3'd1;
            else if (step_dn)
                id_type_d = (id_type == 3'd0) ? ID_LAST : id_type - 3'd1;
        end else begin
            if (step_up)
                nb_des_d = (nb_des == NB_LAST) ? 4'd1 : nb_des + 4'd1;
            else if (step_dn)
                nb_des_d = (nb_des == 4'd1) ? NB_LAST : nb_des - 4'd1;
        end
    end

    assign sel_count = state[0];

    function automatic logic [6:0] face_of(input logic [2:0] idx);
        case (idx)
            3'd0:    face_of = 7'd2;
            3'd1:    face_of = 7'd4;
            3'd2:    face_of = 7'd6;
            3'd3:    face_of = 7'd8;
            3'd4:    face_of = 7'd10;
            3'd5:    face_of = 7'd12;
            3'd6:    face_of = 7'd20;
            default: face_of = 7'd100;
        endcase
    endfunction

    logic [W-1:0]     dmin_d, dmax_d;
    logic             upd;
    logic [DD_W-1:0]  dd, dd_adj;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    assign dmin_d = W'(nb_des);
    assign dmax_d = W'(nb_des) * W'(face_of(id_type));
    assign upd    = (dmin_d != d_min) || (dmax_d != d_max);

    // Double-dabble add-3 correction on the three BCD digits
    always_comb begin
        dd_adj = dd;
        for (int k = 0; k < 3; k++) begin
            if (dd[W + 4*k +: 4] > 4'd4)
                dd_adj[W + 4*k +: 4] = dd[W + 4*k +: 4] + 4'd3;
        end
    end

    // A bound change (re)starts the converter; result published after W shifts plus one load cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_min     <= W'(1);
            d_max     <= W'(2);
            dd        <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            bcd_max   <= 12'h002;
            bcd_valid <= 1'b1;
        end else begin
            d_min <= dmin_d;
            d_max <= dmax_d;
            if (upd) begin
                dd        <= {{BCD_W{1'b0}}, dmax_d};
                cnt       <= '0;
                busy      <= 1'b1;
                bcd_valid <= 1'b0;
            end else if (busy) begin
                if (cnt == CNT_W'(W)) begin
                    bcd_max   <= dd[W +: BCD_W];
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    dd  <= {dd_adj[DD_W-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
